mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_wait_ctr.sv | 34 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_WAIT_CYCLES = 4;
    localparam int unsigned CTR_W           = 8;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times memory wait states; flag marks the last wait cycle.
module mem_wait_ctr
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic             flag
);

    logic [CTR_W-1:0] count_q, count_d;

    // Parks at zero once expired so an idle arbiter never sees a stray flag.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign flag = (count_q == CTR_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a fixed-latency memory.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the D port wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IStrobe,
    input  logic              DStrobe,
    input  logic              IRW,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] IAddr,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] IWData,
    input  logic [DATA_W-1:0] DWData,
    output logic              IReady,
    output logic              DReady,
    output logic [DATA_W-1:0] RData,
    output logic              MStrobe,
    output logic              MRW,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWData,
    input  logic [DATA_W-1:0] MRData,
    output logic              Grant,
    output logic              Busy
);

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_CYCLES);

    arb_state_e        state_q, state_d;
    logic              mstrobe_q, mstrobe_d;
    logic              mrw_q, mrw_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              iready_q, iready_d;
    logic              dready_q, dready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;

    logic any_req;
    logic winner;
    logic ctr_load;
    logic ctr_flag;

    assign any_req  = IStrobe | DStrobe;
    assign ctr_load = (state_q == ISSUE);

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;

    // On a tie the port not served last wins; a lone requester always wins.
    always_comb begin
        if (IStrobe && DStrobe) begin
            winner = ~rr_last_q;
        end else begin
            winner = DStrobe ? PORT_D : PORT_I;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == IDLE && any_req) begin
            rr_last_d = winner;
        end
    end
`else
    assign winner = DStrobe ? PORT_D : PORT_I;
`endif

    mem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (WAIT_LOAD),
        .flag     (ctr_flag)
    );

    always_comb begin
        state_d   = state_q;
        mstrobe_d = 1'b0;
        mrw_d     = mrw_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        iready_d  = 1'b0;
        dready_d  = 1'b0;
        rdata_d   = rdata_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = ISSUE;
                    mstrobe_d = 1'b1;
                    grant_d   = winner;
                    busy_d    = 1'b1;
                    mrw_d     = (winner == PORT_D) ? DRW    : IRW;
                    maddr_d   = (winner == PORT_D) ? DAddr  : IAddr;
                    mwdata_d  = (winner == PORT_D) ? DWData : IWData;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ctr_flag) begin
                    state_d = DONE;
                    if (!mrw_q) begin
                        rdata_d = MRData;
                    end
                    if (grant_q == PORT_D) begin
                        dready_d = 1'b1;
                    end else begin
                        iready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mstrobe_q <= 1'b0;
            mrw_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            iready_q  <= 1'b0;
            dready_q  <= 1'b0;
            rdata_q   <= '0;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mstrobe_q <= mstrobe_d;
            mrw_q     <= mrw_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            iready_q  <= iready_d;
            dready_q  <= dready_d;
            rdata_q   <= rdata_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    assign MStrobe = mstrobe_q;
    assign MRW     = mrw_q;
    assign MAddr   = maddr_q;
    assign MWData  = mwdata_q;
    assign IReady  = iready_q;
    assign DReady  = dready_q;
    assign RData   = rdata_q;
    assign Grant   = grant_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases, randomized run vs. a latency model.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = 4;
    localparam int unsigned W1 = 1;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic          stb  [2];
    logic          rw   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic [DW-1:0] mrdata;
    logic          i_rdy, d_rdy, m_stb, m_rw, grant, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, rdata;

    logic          x_istb;
    logic [AW-1:0] x_iaddr;
    logic [DW-1:0] x_mrdata;
    logic          x_irdy, x_drdy, x_mstb, x_mrw, x_grant, x_busy;
    logic [AW-1:0] x_maddr;
    logic [DW-1:0] x_mwd, x_rdata;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .IStrobe(stb[0]), .DStrobe(stb[1]), .IRW(rw[0]), .DRW(rw[1]),
        .IAddr(addr[0]), .DAddr(addr[1]), .IWData(wd[0]), .DWData(wd[1]),
        .IReady(i_rdy), .DReady(d_rdy), .RData(rdata),
        .MStrobe(m_stb), .MRW(m_rw), .MAddr(m_addr), .MWData(m_wd),
        .MRData(mrdata), .Grant(grant), .Busy(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset),
        .IStrobe(x_istb), .DStrobe(1'b0), .IRW(1'b0), .DRW(1'b0),
        .IAddr(x_iaddr), .DAddr('0), .IWData('0), .DWData('0),
        .IReady(x_irdy), .DReady(x_drdy), .RData(x_rdata),
        .MStrobe(x_mstb), .MRW(x_mrw), .MAddr(x_maddr), .MWData(x_mwd),
        .MRData(x_mrdata), .Grant(x_grant), .Busy(x_busy)
    );

    typedef struct {
        logic          is_d;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mrd;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rand_fields(input int p);
        rw[p]   = 1'($urandom_range(0, 1));
        addr[p] = AW'($urandom);
        wd[p]   = DW'($urandom);
    endtask

    task automatic reset_dut();
        reset  = 1'b0;
        stb[0] = 1'b0;
        stb[1] = 1'b0;
        x_istb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mstrobe", m_stb, 0);
        chk("rst_mrw", m_rw, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwdata", m_wd, 0);
        chk("rst_iready", i_rdy, 0);
        chk("rst_dready", d_rdy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x_busy", x_busy, 0);
        reset = 1'b1;
    endtask

    // One single-requester access; requester drops and scrambles its inputs once accepted.
    task automatic run_vec(input vec_t v, input string tag);
        stb[v.is_d]  = 1'b1;
        rw[v.is_d]   = v.rw;
        addr[v.is_d] = v.addr;
        wd[v.is_d]   = v.wdata;
        mrdata       = v.mrd;
        @(negedge clk);
        for (int unsigned c = 1; c <= W + 2; c++) begin
            chk({tag, "_mstrobe"}, m_stb, (c == 1));
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_grant"}, grant, v.is_d);
            chk({tag, "_mrw"}, m_rw, v.rw);
            chk({tag, "_maddr"}, m_addr, v.addr);
            chk({tag, "_mwdata"}, m_wd, v.wdata);
            chk({tag, "_iready"}, i_rdy, (c == W + 2) && !v.is_d);
            chk({tag, "_dready"}, d_rdy, (c == W + 2) && v.is_d);
            if (c == W + 2) chk({tag, "_rdata"}, rdata, v.exp_rdata);
            stb[0] = 1'b0;
            stb[1] = 1'b0;
            rand_fields(0);
            rand_fields(1);
            @(negedge clk);
        end
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ready"}, {i_rdy, d_rdy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1);
    end

    initial begin
        logic          exp2;
        int unsigned   mk;
        logic          mg, mlast, mrw_e;
        logic [AW-1:0] maddr_e;
        logic [DW-1:0] mwd_e, mrdata_e;

        for (int p = 0; p < 2; p++) begin
            stb[p] = 1'b0; rw[p] = 1'b0; addr[p] = '0; wd[p] = '0;
        end
        mrdata = '0; x_istb = 1'b0; x_iaddr = '0; x_mrdata = '0;

        tbl[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'h00FF, 16'h5555, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b0, 16'h0ABC, 16'h3C3C, 16'h1357, 16'h1357};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000, 16'h1357};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF};

        reset_dut();
        for (int i = 0; i < 6; i++) run_vec(tbl[i], "tbl");

        // Simultaneous requests held across two back-to-back accesses.
        reset_dut();
        exp2 = RR ? 1'b0 : 1'b1;
        stb[0] = 1'b1; rw[0] = 1'b0; addr[0] = 16'h0111;
        stb[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0222;
        mrdata = 16'h4444;
        @(negedge clk);
        chk("tie1_grant", grant, 1);
        chk("tie1_mstrobe", m_stb, 1);
        chk("tie1_maddr", m_addr, 16'h0222);
        repeat (W + 1) @(negedge clk);
        chk("tie1_dready", d_rdy, 1);
        chk("tie1_iready", i_rdy, 0);
        @(negedge clk);
        chk("tie_gap_busy", busy, 0);
        @(negedge clk);
        chk("tie2_grant", grant, exp2);
        chk("tie2_mstrobe", m_stb, 1);
        chk("tie2_maddr", m_addr, exp2 ? 16'h0222 : 16'h0111);
        stb[0] = 1'b0; stb[1] = 1'b0;
        repeat (W + 1) @(negedge clk);
        chk("tie2_iready", i_rdy, !exp2);
        chk("tie2_dready", d_rdy, exp2);
        @(negedge clk);

        // D request arriving while an I access is in flight.
        stb[0] = 1'b1; rw[0] = 1'b0; addr[0] = 16'h0040;
        mrdata = 16'h2222;
        @(negedge clk);
        for (int unsigned c = 1; c <= W + 2; c++) begin
            chk("late_d_mstrobe", m_stb, (c == 1));
            chk("late_d_grant_i", grant, 0);
            chk("late_d_iready", i_rdy, (c == W + 2));
            chk("late_d_dready_early", d_rdy, 0);
            if (c == 1) stb[0] = 1'b0;
            if (c == 2) begin stb[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0D0D; end
            @(negedge clk);
        end
        chk("late_d_gap_busy", busy, 0);
        chk("late_d_gap_mstrobe", m_stb, 0);
        @(negedge clk);
        chk("late_d_grant", grant, 1);
        chk("late_d_issue", m_stb, 1);
        chk("late_d_maddr", m_addr, 16'h0D0D);
        stb[1] = 1'b0;
        repeat (W + 1) @(negedge clk);
        chk("late_d_dready", d_rdy, 1);
        chk("late_d_rdata", rdata, 16'h2222);
        @(negedge clk);

        // Reset asserted in the third wait cycle.
        stb[0] = 1'b1; rw[0] = 1'b0; addr[0] = 16'h0333;
        mrdata = 16'h7777;
        @(negedge clk);
        stb[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_mstrobe", m_stb, 0);
        chk("midrst_mrw", m_rw, 0);
        chk("midrst_maddr", m_addr, 0);
        chk("midrst_mwdata", m_wd, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ready", {i_rdy, d_rdy}, 0);
        end
        reset = 1'b1;
        run_vec('{1'b0, 1'b0, 16'h0444, 16'h0000, 16'h8888, 16'h8888}, "postrst");

        // Single wait state: two back-to-back reads on the second instance.
        x_istb = 1'b1; x_iaddr = 16'h0050; x_mrdata = 16'h9999;
        for (int unsigned c = 1; c <= 8; c++) begin
            int unsigned ph;
            @(negedge clk);
            ph = (c - 1) % (W1 + 3);
            chk("w1_mstrobe", x_mstb, (ph == 0));
            chk("w1_iready", x_irdy, (ph == W1 + 1));
            chk("w1_busy", x_busy, (ph != W1 + 2));
            chk("w1_dready", x_drdy, 0);
            if (ph == 0) begin
                chk("w1_maddr", x_maddr, 16'h0050);
                chk("w1_grant", x_grant, 0);
                chk("w1_mrw", x_mrw, 0);
                chk("w1_mwdata", x_mwd, 0);
            end
            if (c == 3) chk("w1_rdata1", x_rdata, 16'h9999);
            if (c == 7) chk("w1_rdata2", x_rdata, 16'hAAAA);
            if (c == 4) x_mrdata = 16'hAAAA;
            if (c == 7) x_istb = 1'b0;
        end

        // Randomized traffic against a latency-based reference model.
        reset_dut();
        mk = 0; mg = 1'b0; mlast = 1'b0; mrw_e = 1'b0;
        maddr_e = '0; mwd_e = '0; mrdata_e = '0;
        for (int n = 0; n < 2000; n++) begin
            chk("rnd_mstrobe", m_stb, (mk == 1));
            chk("rnd_busy", busy, (mk != 0));
            chk("rnd_iready", i_rdy, (mk == W + 2) && !mg);
            chk("rnd_dready", d_rdy, (mk == W + 2) && mg);
            chk("rnd_rdata", rdata, mrdata_e);
            if (mk != 0) begin
                chk("rnd_grant", grant, mg);
                chk("rnd_mrw", m_rw, mrw_e);
                chk("rnd_maddr", m_addr, maddr_e);
                chk("rnd_mwdata", m_wd, mwd_e);
            end
            for (int p = 0; p < 2; p++) begin
                if (mk == W + 2 && mg == p[0]) begin
                    stb[p] = ($urandom_range(0, 3) == 0);
                    if (stb[p]) rand_fields(p);
                end else if (!stb[p]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        stb[p] = 1'b1;
                        rand_fields(p);
                    end
                end else if (mk != 0 && mg == p[0]) begin
                    case ($urandom_range(0, 9))
                        0:       stb[p] = 1'b0;
                        1, 2:    rand_fields(p);
                        default: ;
                    endcase
                end
            end
            mrdata = DW'($urandom);
            if (mk == 0) begin
                if (stb[0] || stb[1]) begin
                    if (stb[0] && stb[1]) mg = RR ? !mlast : 1'b1;
                    else                  mg = stb[1];
                    mlast   = mg;
                    mrw_e   = rw[mg];
                    maddr_e = addr[mg];
                    mwd_e   = wd[mg];
                    mk      = 1;
                end
            end else if (mk == W + 2) begin
                mk = 0;
            end else begin
                if (mk == W + 1 && !mrw_e) mrdata_e = mrdata;
                mk++;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
